boot_sequencer: RTL and testbench

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

---
 rtl/cpu_pkg.sv | 15 +
 rtl/boot_sequencer_if.sv | 27 ++
 rtl/btn_sync_edge.sv | 21 ++
 rtl/boot_sequencer.sv | 136 +++++++++++++
 tb/tb_boot_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: boot sequencer state encodings and the stack-pointer register index.
package cpu_pkg;

    typedef enum logic [2:0] {
        BS_INIT  = 3'd0,
        BS_LOAD  = 3'd1,
        BS_READY = 3'd2,
        BS_EXEC  = 3'd3,
        BS_HALT  = 3'd4,
        BS_ERR   = 3'd5
    } boot_state_t;

    localparam int SP_REG_IDX = 28;

endpackage

// File: rtl/boot_sequencer_if.sv
// Handshake bundle between boot_sequencer (master) and the loader/core/board side (slave).
interface boot_sequencer_if #(
    parameter int MEM_INST_SIZE = 1024
);
    localparam int LW = $clog2(MEM_INST_SIZE) + 1;

    logic          load_req;
    logic          load_done;
    logic [LW-1:0] load_words;
    logic          core_pc_rst;
    logic          sp_we;
    logic [31:0]   sp_val;
    logic          core_run;
    logic          core_halt;
    logic [2:0]    mode;
    logic [1:0]    LED;

    modport master (
        output load_req, core_pc_rst, sp_we, sp_val, core_run, mode, LED,
        input  load_done, load_words, core_halt
    );

    modport slave (
        input  load_req, core_pc_rst, sp_we, sp_val, core_run, mode, LED,
        output load_done, load_words, core_halt
    );
endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous push-button level plus a rising-edge detector.
module btn_sync_edge (
    input  logic CLK,
    input  logic INITIALIZE,
    input  logic async_in,
    output logic rise_pulse
);
    // [0],[1] form the synchronizer; [2] holds the previous synchronized level.
    logic [2:0] sync_q;

    // NOTE: non-blocking assignments so every flop samples pre-edge values; blocking would collapse the chain.
    always_ff @(posedge CLK or posedge INITIALIZE) begin
        if (INITIALIZE) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], async_in};
        end
    end

    assign rise_pulse = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: init pulses, program load handshake, start/run/halt control of the core.
// Optional execution watchdog enabled by defining BOOT_SEQ_WDOG_EN.
module boot_sequencer
    import cpu_pkg::*;
#(
    parameter int          MEM_SIZE      = 1024,
    parameter int          MEM_INST_SIZE = 1024,
    parameter logic [31:0] WDOG_CYCLES   = 32'd100_000_000
) (
    input  logic             CLK,
    input  logic             INITIALIZE,
    input  logic             START_EXEC,
    boot_sequencer_if.master bus
);
    localparam logic [2:0] S_INIT  = 3'(BS_INIT);
    localparam logic [2:0] S_LOAD  = 3'(BS_LOAD);
    localparam logic [2:0] S_READY = 3'(BS_READY);
    localparam logic [2:0] S_EXEC  = 3'(BS_EXEC);
    localparam logic [2:0] S_HALT  = 3'(BS_HALT);
    localparam logic [2:0] S_ERR   = 3'(BS_ERR);

    logic [2:0]  state;
    logic        load_req_q;
    logic        core_run_q;
    logic        core_pc_rst_q;
    logic        sp_we_q;
    logic [1:0]  led_q;
    logic        start_pe;
    logic        wdog_expired;
    logic [31:0] words_wide;
    logic        words_bad;

    btn_sync_edge u_btn_sync_edge (
        .CLK        (CLK),
        .INITIALIZE (INITIALIZE),
        .async_in   (START_EXEC),
        .rise_pulse (start_pe)
    );

    assign words_wide = 32'(bus.load_words);
    assign words_bad  = (words_wide == 32'd0) || (words_wide > 32'(MEM_INST_SIZE));

`ifdef BOOT_SEQ_WDOG_EN
    logic [31:0] wdog;

    // Cleared on the READY->EXEC transition so the first EXEC cycle sees zero.
    always_ff @(posedge CLK or posedge INITIALIZE) begin
        if (INITIALIZE) begin
            wdog <= 32'd0;
        end else if (state == S_READY && start_pe) begin
            wdog <= 32'd0;
        end else if (state == S_EXEC) begin
            wdog <= wdog + 32'd1;
        end
    end

    assign wdog_expired = (state == S_EXEC) && (wdog == WDOG_CYCLES - 32'd1);
`else
    logic unused_wdog;
    assign unused_wdog  = ^WDOG_CYCLES;
    assign wdog_expired = 1'b0;
`endif

    always_ff @(posedge CLK or posedge INITIALIZE) begin
        if (INITIALIZE) begin
            state         <= S_INIT;
            load_req_q    <= 1'b0;
            core_run_q    <= 1'b0;
            core_pc_rst_q <= 1'b0;
            sp_we_q       <= 1'b0;
            led_q         <= 2'b00;
        end else begin
            // NOTE: pulses default low every cycle; the case arms below override only where they fire.
            core_pc_rst_q <= 1'b0;
            sp_we_q       <= 1'b0;
            case (state)
                S_INIT: begin
                    // First cycle after reset emits the pulses; the cycle after moves on.
                    if (!sp_we_q) begin
                        sp_we_q       <= 1'b1;
                        core_pc_rst_q <= 1'b1;
                    end else begin
                        state      <= S_LOAD;
                        load_req_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (bus.load_done) begin
                        load_req_q <= 1'b0;
                        if (words_bad) begin
                            state <= S_ERR;
                            led_q <= 2'b10;
                        end else begin
                            state <= S_READY;
                        end
                    end
                end
                S_READY: begin
                    if (start_pe) begin
                        state         <= S_EXEC;
                        core_pc_rst_q <= 1'b1;
                        core_run_q    <= 1'b1;
                        led_q         <= 2'b01;
                    end
                end
                S_EXEC: begin
                    // A halt in the same cycle as watchdog expiry takes precedence.
                    if (bus.core_halt) begin
                        state      <= S_HALT;
                        core_run_q <= 1'b0;
                    end else if (wdog_expired) begin
                        state      <= S_ERR;
                        core_run_q <= 1'b0;
                        led_q      <= 2'b10;
                    end
                end
                S_HALT, S_ERR: begin
                end
                default: begin
                    state      <= S_ERR;
                    load_req_q <= 1'b0;
                    core_run_q <= 1'b0;
                    led_q      <= 2'b10;
                end
            endcase
        end
    end

    assign bus.load_req    = load_req_q;
    assign bus.core_run    = core_run_q;
    assign bus.core_pc_rst = core_pc_rst_q;
    assign bus.sp_we       = sp_we_q;
    assign bus.sp_val      = 32'(MEM_SIZE / 2);
    assign bus.mode        = state;
    assign bus.LED         = led_q;
endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer: directed table, corner sequences and randomized traffic vs a reference model.
module tb_boot_sequencer;
    localparam int          MEM_INST = 1024;
    localparam logic [31:0] WDOG     = 32'd16;
`ifdef BOOT_SEQ_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic CLK = 1'b0;
    logic INITIALIZE = 1'b1;
    logic START_EXEC = 1'b0;
    bit   pin_lvl = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    boot_sequencer_if #(.MEM_INST_SIZE(MEM_INST)) bus ();

    boot_sequencer #(
        .MEM_SIZE      (1024),
        .MEM_INST_SIZE (MEM_INST),
        .WDOG_CYCLES   (WDOG)
    ) dut (
        .CLK        (CLK),
        .INITIALIZE (INITIALIZE),
        .START_EXEC (START_EXEC),
        .bus        (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference model: mode number per the state rules, edge counting for the
    // synchronizer delay and the watchdog, pulses derived per edge.
    int m_mode;
    bit m_pulsed;
    int m_edge;
    int m_entry;
    bit m_sp_we;
    bit m_pc_rst;
    bit hist[$];

    function automatic void model_reset();
        m_mode   = 0;
        m_pulsed = 1'b0;
        m_edge   = 0;
        m_entry  = 0;
        m_sp_we  = 1'b0;
        m_pc_rst = 1'b0;
        hist.delete();
        hist.push_back(1'b0);
    endfunction

    function automatic void model_edge(bit ld, int words, bit halt, bit pin);
        bit spe;
        m_edge++;
        hist.push_back(pin);
        // The pin level sampled at edge m is seen as a rising edge at edge m+2.
        spe = (m_edge >= 2) && hist[m_edge-2] && !((m_edge >= 3) && hist[m_edge-3]);
        m_sp_we  = 1'b0;
        m_pc_rst = 1'b0;
        case (m_mode)
            0: if (!m_pulsed) begin
                   m_pulsed = 1'b1;
                   m_sp_we  = 1'b1;
                   m_pc_rst = 1'b1;
               end else begin
                   m_mode = 1;
               end
            1: if (ld) m_mode = (words == 0 || words > MEM_INST) ? 5 : 2;
            2: if (spe) begin
                   m_mode   = 3;
                   m_pc_rst = 1'b1;
                   m_entry  = m_edge;
               end
            3: if (halt) m_mode = 4;
               else if (WDOG_ON && (m_edge - m_entry) == int'(WDOG)) m_mode = 5;
            default: ;
        endcase
    endfunction

    function automatic int model_led();
        if (m_mode == 3 || m_mode == 4) return 1;
        if (m_mode == 5) return 2;
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check($sformatf("mode@%0d", m_edge),     32'(bus.mode),        32'(m_mode));
        check($sformatf("load_req@%0d", m_edge), 32'(bus.load_req),    32'(m_mode == 1));
        check($sformatf("core_run@%0d", m_edge), 32'(bus.core_run),    32'(m_mode == 3));
        check($sformatf("LED@%0d", m_edge),      32'(bus.LED),         32'(model_led()));
        check($sformatf("sp_we@%0d", m_edge),    32'(bus.sp_we),       32'(m_sp_we));
        check($sformatf("pc_rst@%0d", m_edge),   32'(bus.core_pc_rst), 32'(m_pc_rst));
    endtask

    task automatic step(input bit ld, input int words, input bit halt, input bit pin);
        bus.load_done  = ld;
        bus.load_words = 11'(words);
        bus.core_halt  = halt;
        START_EXEC     = pin;
        @(posedge CLK);
        model_edge(ld, words, halt, pin);
        #1;
        compare_all();
        bus.load_done = 1'b0;
        bus.core_halt = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, pin_lvl);
    endtask

    // Asserts reset at a non-edge time, checks the asynchronous clear, releases mid-cycle.
    task automatic apply_reset();
        INITIALIZE = 1'b1;
        bus.load_done  = 1'b0;
        bus.core_halt  = 1'b0;
        bus.load_words = '0;
        #1;
        check("rst_async_mode",     32'(bus.mode),        32'd0);
        check("rst_async_core_run", 32'(bus.core_run),    32'd0);
        check("rst_async_load_req", 32'(bus.load_req),    32'd0);
        check("rst_async_LED",      32'(bus.LED),         32'd0);
        check("rst_async_sp_we",    32'(bus.sp_we),       32'd0);
        check("rst_async_pc_rst",   32'(bus.core_pc_rst), 32'd0);
        @(posedge CLK);
        #1;
        check("rst_held_mode",  32'(bus.mode),  32'd0);
        check("rst_held_sp_we", 32'(bus.sp_we), 32'd0);
        #3;
        INITIALIZE = 1'b0;
        model_reset();
    endtask

    task automatic to_load();
        pin_lvl = 1'b0;
        idle(2);
    endtask

    // Pin pulse of two cycles; DUT must reach EXEC within four cycles of the pin edge.
    task automatic start_and_wait(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            pin_lvl = (i < 2);
            step(1'b0, 0, 1'b0, pin_lvl);
            seen = (bus.mode == 3'd3);
        end
        pin_lvl = 1'b0;
        check(name, 32'(seen), 32'd1);
    endtask

    typedef struct {
        int       words;
        bit [2:0] exp_mode;
        bit [1:0] exp_led;
        bit [2:0] exp_after_start;
    } load_vec_t;

    load_vec_t vecs[6];

    initial begin
        vecs[0] = '{37,   3'd2, 2'b00, 3'd3};
        vecs[1] = '{0,    3'd5, 2'b10, 3'd5};
        vecs[2] = '{1025, 3'd5, 2'b10, 3'd5};
        vecs[3] = '{1024, 3'd2, 2'b00, 3'd3};
        vecs[4] = '{1,    3'd2, 2'b00, 3'd3};
        vecs[5] = '{2047, 3'd5, 2'b10, 3'd5};

        bus.load_done  = 1'b0;
        bus.core_halt  = 1'b0;
        bus.load_words = '0;

        // Reset release: one-cycle init pulses, then LOAD.
        apply_reset();
        step(1'b0, 0, 1'b0, 1'b0);
        check("init_sp_we",  32'(bus.sp_we),       32'd1);
        check("init_pc_rst", 32'(bus.core_pc_rst), 32'd1);
        check("init_sp_val", bus.sp_val,           32'd512);
        step(1'b0, 0, 1'b0, 1'b0);
        check("init_mode_load", 32'(bus.mode),     32'd1);
        check("init_load_req",  32'(bus.load_req), 32'd1);
        check("init_sp_we_off", 32'(bus.sp_we),    32'd0);

        // Load 37 words, start, then halt; a later start is ignored.
        step(1'b1, 37, 1'b0, 1'b0);
        check("load37_mode",     32'(bus.mode),     32'd2);
        check("load37_load_req", 32'(bus.load_req), 32'd0);
        start_and_wait("start_reaches_exec");
        check("exec_core_run", 32'(bus.core_run), 32'd1);
        check("exec_LED",      32'(bus.LED),      32'd1);
        idle(3);
        step(1'b0, 0, 1'b1, 1'b0);
        check("halt_mode",     32'(bus.mode),     32'd4);
        check("halt_core_run", 32'(bus.core_run), 32'd0);
        check("halt_LED",      32'(bus.LED),      32'd1);
        pin_lvl = 1'b1;
        idle(3);
        pin_lvl = 1'b0;
        idle(4);
        check("halt_ignores_start", 32'(bus.mode), 32'd4);

        // Word-count table: accepted counts go READY then EXEC, bad counts lock in ERR.
        foreach (vecs[i]) begin
            apply_reset();
            to_load();
            step(1'b1, vecs[i].words, 1'b0, 1'b0);
            check($sformatf("tbl_mode_w%0d", vecs[i].words),     32'(bus.mode),     32'(vecs[i].exp_mode));
            check($sformatf("tbl_LED_w%0d", vecs[i].words),      32'(bus.LED),      32'(vecs[i].exp_led));
            check($sformatf("tbl_load_req_w%0d", vecs[i].words), 32'(bus.load_req), 32'd0);
            pin_lvl = 1'b1;
            idle(2);
            pin_lvl = 1'b0;
            idle(3);
            check($sformatf("tbl_after_start_w%0d", vecs[i].words), 32'(bus.mode), 32'(vecs[i].exp_after_start));
        end

        // load_done and start_pe on the same edge: READY only; a fresh edge is needed.
        apply_reset();
        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        check("coinc_in_load", 32'(bus.mode), 32'd1);
        step(1'b1, 9, 1'b0, 1'b1);
        check("coinc_ready_only", 32'(bus.mode), 32'd2);
        pin_lvl = 1'b1;
        idle(6);
        check("coinc_no_run_without_edge", 32'(bus.mode), 32'd2);
        pin_lvl = 1'b0;
        idle(1);
        start_and_wait("coinc_new_edge_runs");

        // Sixteen EXEC cycles without halt: watchdog build errors out, default build keeps running.
        apply_reset();
        to_load();
        step(1'b1, 5, 1'b0, 1'b0);
        start_and_wait("wdog_enter_exec");
        idle(15);
        check("wdog_cycle15_still_exec", 32'(bus.mode), 32'd3);
        idle(1);
        check("wdog_after_16", 32'(bus.mode), WDOG_ON ? 32'd5 : 32'd3);
        check("wdog_after_16_LED", 32'(bus.LED), WDOG_ON ? 32'd2 : 32'd1);

        // Halt coinciding with expiry: halt wins.
        apply_reset();
        to_load();
        step(1'b1, 5, 1'b0, 1'b0);
        start_and_wait("wdog_halt_enter_exec");
        idle(15);
        step(1'b0, 0, 1'b1, 1'b0);
        check("wdog_halt_wins", 32'(bus.mode), 32'd4);

        // Reset in the middle of EXEC drops core_run at once, then the init sequence repeats.
        apply_reset();
        to_load();
        step(1'b1, 100, 1'b0, 1'b0);
        start_and_wait("midexec_enter");
        idle(2);
        apply_reset();
        step(1'b0, 0, 1'b0, 1'b0);
        check("rerun_sp_we",  32'(bus.sp_we),       32'd1);
        check("rerun_pc_rst", 32'(bus.core_pc_rst), 32'd1);
        step(1'b0, 0, 1'b0, 1'b0);
        check("rerun_mode_load", 32'(bus.mode), 32'd1);

        // Randomized traffic against the model.
        for (int run = 0; run < 15; run++) begin
            apply_reset();
            pin_lvl = 1'b0;
            for (int c = 0; c < 70; c++) begin
                bit ld;
                bit halt;
                int w;
                int r;
                if ($urandom_range(0, 5) == 0) pin_lvl = ~pin_lvl;
                ld = ($urandom_range(0, 7) == 0);
                r  = int'($urandom_range(0, 9));
                if (r == 0)      w = 0;
                else if (r == 1) w = int'($urandom_range(1025, 2047));
                else             w = int'($urandom_range(1, 1024));
                halt = ($urandom_range(0, 9) == 0);
                step(ld, w, halt, pin_lvl);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
